// File: rtl/scarv_cop_permute_seq_pkg.sv
// Shared definitions for the sequential permutation unit: subclass codes,
// FSM state encodings and the per-lane byte permute helper.
package scarv_cop_permute_seq_pkg;

  localparam logic [4:0] SCARV_COP_SCLASS_PERM_BIT  = 5'b00001;
  localparam logic [4:0] SCARV_COP_SCLASS_PERM_IBIT = 5'b00010;
  localparam logic [4:0] SCARV_COP_SCLASS_PERM_BYTE = 5'b00100;

  typedef enum logic [1:0] {
    SCARV_COP_PERM_IDLE = 2'd0,
    SCARV_COP_PERM_RUN  = 2'd1,
    SCARV_COP_PERM_DONE = 2'd2
  } perm_state_e;

  // Byte permute of one 32-bit lane. sel[7:6] picks the source of output
  // byte 0, sel[5:4] byte 1, sel[3:2] byte 2 and sel[1:0] byte 3.
  function automatic logic [31:0] pbyte_lane(input logic [31:0] w, input logic [7:0] sel);
    logic [31:0] r;
    logic [31:0] t;
    r = 32'h0000_0000;
    t = w >> {sel[7:6], 3'b000};
    r[7:0]   = t[7:0];
    t = w >> {sel[5:4], 3'b000};
    r[15:8]  = t[7:0];
    t = w >> {sel[3:2], 3'b000};
    r[23:16] = t[7:0];
    t = w >> {sel[1:0], 3'b000};
    r[31:24] = t[7:0];
    return r;
  endfunction

endpackage

// File: rtl/scarv_cop_permute_seq_layer.sv
// One combinational butterfly layer with a runtime partner distance.
// Each bit either keeps its own value (mask set or layer disabled) or takes
// the value of its partner bit; this is a per-bit select, not a swap.
module scarv_cop_perm_layer #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]          data_i,
  input  logic [XLEN-1:0]          mask_i,
  input  logic                     en_i,
  input  logic [$clog2(XLEN)-1:0]  dist_i,
  output logic [XLEN-1:0]          data_o
);

  localparam int L = $clog2(XLEN);

  // Per-bit select between own bit and partner bit j XOR dist.
  always_comb begin
    logic [L-1:0] alt;
    data_o = data_i;
    alt    = '0;
    for (int j = 0; j < XLEN; j++) begin
      alt = L'(j) ^ dist_i;
      if (!en_i || mask_i[j]) begin
        data_o[j] = data_i[j];
      end else begin
        data_o[j] = data_i[alt];
      end
    end
  end

endmodule

// File: rtl/scarv_cop_permute_seq.sv
// Sequential permutation unit for xc.pbit / xc.ipbit / xc.pbyte.
// Applies LPC butterfly layers per cycle; latency depends only on the
// subclass, never on operand data. Outputs are registered and masked to
// zero outside the single idone cycle.
module scarv_cop_permute_seq
  import scarv_cop_permute_seq_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int LPC  = 1
) (
  input  logic              g_clk,
  input  logic              g_reset,
  input  logic              perm_ivalid,
  output logic              perm_idone,
  output logic              perm_busy,
  input  logic [XLEN-1:0]   perm_rs1,
  input  logic [XLEN-1:0]   perm_rs3,
  input  logic [31:0]       id_imm,
  input  logic [4:0]        id_subclass,
  output logic [XLEN/8-1:0] perm_cpr_rd_ben,
  output logic [XLEN-1:0]   perm_cpr_rd_wdata
);

  localparam int              L     = $clog2(XLEN);
  localparam int              KW    = 8;
  localparam int              LANES = XLEN / 32;
  localparam logic [KW-1:0]   L_K   = KW'(L);
  localparam logic [KW-1:0]   LPC_K = KW'(LPC);
  localparam logic [L-1:0]    ONE_L = {{(L-1){1'b0}}, 1'b1};

  perm_state_e       state_q, state_d;
  logic [KW-1:0]     k_q, k_d;
  logic [XLEN-1:0]   work_q, work_d;
  logic [XLEN-1:0]   mask_q, mask_d;
  logic [L-1:0]      cs_q, cs_d;
  logic              inv_q, inv_d;
  logic              idone_q, idone_d;
  logic              busy_q, busy_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [XLEN/8-1:0] ben_q, ben_d;

  logic [XLEN-1:0]   stage_s [0:LPC];
  logic [XLEN-1:0]   pbyte_s;
  logic              unused_s;

  assign unused_s   = ^{id_imm[31:10], id_imm[1:0]};
  assign stage_s[0] = work_q;

  // Chain of LPC layers; slots past the last layer are disabled pass-throughs.
  for (genvar p = 0; p < LPC; p++) begin : g_stage
    logic [KW-1:0] li_s;
    logic [L-1:0]  onehot_s;
    logic          en_s;
    logic [L-1:0]  dist_s;

    // Layer index, enable and partner distance for this slot.
    always_comb begin
      li_s     = k_q + KW'(p);
      onehot_s = ONE_L << li_s;
      if (li_s < L_K) begin
        en_s   = |(cs_q & onehot_s);
        dist_s = inv_q ? (ONE_L << (L_K - KW'(1) - li_s)) : onehot_s;
      end else begin
        en_s   = 1'b0;
        dist_s = '0;
      end
    end

    scarv_cop_perm_layer #(.XLEN(XLEN)) u_layer (
      .data_i (stage_s[p]),
      .mask_i (mask_q),
      .en_i   (en_s),
      .dist_i (dist_s),
      .data_o (stage_s[p+1])
    );
  end

  // Byte permute of rs1, evaluated in the accept cycle.
  always_comb begin
    pbyte_s = '0;
    for (int n = 0; n < LANES; n++) begin
      pbyte_s[32*n +: 32] = pbyte_lane(perm_rs1[32*n +: 32], id_imm[9:2]);
    end
  end

  // Next-state, datapath update and next registered outputs.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    work_d  = work_q;
    mask_d  = mask_q;
    cs_d    = cs_q;
    inv_d   = inv_q;
    idone_d = 1'b0;
    busy_d  = 1'b0;
    wdata_d = '0;
    ben_d   = '0;
    case (state_q)
      SCARV_COP_PERM_IDLE: begin
        if (perm_ivalid) begin
          mask_d = perm_rs1;
          cs_d   = id_imm[5 +: L];
          busy_d = 1'b1;
          case (id_subclass)
            SCARV_COP_SCLASS_PERM_BIT,
            SCARV_COP_SCLASS_PERM_IBIT: begin
              state_d = SCARV_COP_PERM_RUN;
              k_d     = '0;
              work_d  = perm_rs3;
              inv_d   = (id_subclass == SCARV_COP_SCLASS_PERM_IBIT);
            end
            SCARV_COP_SCLASS_PERM_BYTE: begin
              state_d = SCARV_COP_PERM_DONE;
              idone_d = 1'b1;
              wdata_d = pbyte_s;
              ben_d   = '1;
            end
            default: begin
              state_d = SCARV_COP_PERM_DONE;
              idone_d = 1'b1;
            end
          endcase
        end else begin
          state_d = SCARV_COP_PERM_IDLE;
        end
      end
      SCARV_COP_PERM_RUN: begin
        if (!perm_ivalid) begin
          state_d = SCARV_COP_PERM_IDLE;
          work_d  = '0;
          k_d     = '0;
        end else begin
          busy_d = 1'b1;
          work_d = stage_s[LPC];
          k_d    = k_q + LPC_K;
          if ((k_q + LPC_K) >= L_K) begin
            state_d = SCARV_COP_PERM_DONE;
            idone_d = 1'b1;
            wdata_d = stage_s[LPC];
            ben_d   = '1;
          end else begin
            state_d = SCARV_COP_PERM_RUN;
          end
        end
      end
      SCARV_COP_PERM_DONE: begin
        state_d = SCARV_COP_PERM_IDLE;
        work_d  = '0;
        k_d     = '0;
      end
      default: begin
        state_d = SCARV_COP_PERM_IDLE;
        work_d  = '0;
        k_d     = '0;
      end
    endcase
  end

  // State, working data and output registers.
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      state_q <= SCARV_COP_PERM_IDLE;
      k_q     <= '0;
      work_q  <= '0;
      mask_q  <= '0;
      cs_q    <= '0;
      inv_q   <= 1'b0;
      idone_q <= 1'b0;
      busy_q  <= 1'b0;
      wdata_q <= '0;
      ben_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      work_q  <= work_d;
      mask_q  <= mask_d;
      cs_q    <= cs_d;
      inv_q   <= inv_d;
      idone_q <= idone_d;
      busy_q  <= busy_d;
      wdata_q <= wdata_d;
      ben_q   <= ben_d;
    end
  end

  assign perm_idone        = idone_q;
  assign perm_busy         = busy_q;
  assign perm_cpr_rd_wdata = wdata_q;
  assign perm_cpr_rd_ben   = ben_q;

endmodule

// File: tb/tb_scarv_cop_permute_seq.sv
// Directed bench: a 32-bit/LPC=1 instance and a 64-bit/LPC=2 instance,
// a vector table plus hand sequences for abort, reset and re-accept.
module tb_scarv_cop_permute_seq;
  import scarv_cop_permute_seq_pkg::*;

  logic        g_clk = 1'b0;
  logic        g_reset;
  logic        a_ivalid, b_ivalid;
  logic        a_idone, b_idone, a_busy, b_busy;
  logic [63:0] rs1, rs3;
  logic [31:0] imm;
  logic [4:0]  sub;
  logic [3:0]  a_ben;
  logic [7:0]  b_ben;
  logic [31:0] a_wdata;
  logic [63:0] b_wdata;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 g_clk = ~g_clk;

  scarv_cop_permute_seq #(.XLEN(32), .LPC(1)) dut_a (
    .g_clk(g_clk), .g_reset(g_reset), .perm_ivalid(a_ivalid), .perm_idone(a_idone),
    .perm_busy(a_busy), .perm_rs1(rs1[31:0]), .perm_rs3(rs3[31:0]), .id_imm(imm),
    .id_subclass(sub), .perm_cpr_rd_ben(a_ben), .perm_cpr_rd_wdata(a_wdata));

  scarv_cop_permute_seq #(.XLEN(64), .LPC(2)) dut_b (
    .g_clk(g_clk), .g_reset(g_reset), .perm_ivalid(b_ivalid), .perm_idone(b_idone),
    .perm_busy(b_busy), .perm_rs1(rs1), .perm_rs3(rs3), .id_imm(imm),
    .id_subclass(sub), .perm_cpr_rd_ben(b_ben), .perm_cpr_rd_wdata(b_wdata));

  typedef struct {
    bit          wide;
    logic [4:0]  sub;
    logic [31:0] imm;
    logic [63:0] rs1;
    logic [63:0] rs3;
    logic [63:0] exp_wd;
    logic [7:0]  exp_ben;
    int          exp_lat;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Reference permutation straight from the layer definition.
  function automatic logic [63:0] model(input int lg, input bit inv, input logic [5:0] cs,
                                        input logic [63:0] m, input logic [63:0] x);
    logic [63:0] y;
    int d;
    for (int i = 0; i < lg; i++) begin
      if (cs[i]) begin
        d = inv ? (1 << (lg - 1 - i)) : (1 << i);
        y = x;
        for (int j = 0; j < (1 << lg); j++) if (!m[j]) y[j] = x[j ^ d];
        x = y;
      end
    end
    return x;
  endfunction

  function automatic vec_t mk(input bit w, input logic [4:0] s, input logic [31:0] im,
                              input logic [63:0] r1, input logic [63:0] r3,
                              input logic [63:0] wd, input logic [7:0] be, input int lat);
    vec_t v;
    v.wide = w; v.sub = s; v.imm = im; v.rs1 = r1; v.rs3 = r3;
    v.exp_wd = wd; v.exp_ben = be; v.exp_lat = lat;
    return v;
  endfunction

  task automatic drive(input bit wide, input bit v, input logic [4:0] s, input logic [31:0] im,
                       input logic [63:0] r1, input logic [63:0] r3);
    sub = s; imm = im; rs1 = r1; rs3 = r3;
    if (wide) b_ivalid = v; else a_ivalid = v;
  endtask

  function automatic logic cur_idone(input bit wide);
    return wide ? b_idone : a_idone;
  endfunction

  function automatic logic cur_busy(input bit wide);
    return wide ? b_busy : a_busy;
  endfunction

  // Issue one operation, hold ivalid until idone, report latency and result.
  task automatic run_op(input bit wide, input logic [4:0] s, input logic [31:0] im,
                        input logic [63:0] r1, input logic [63:0] r3,
                        output int lat, output logic [63:0] wd, output logic [7:0] be,
                        output bit proto_ok);
    bit got;
    got = 1'b0; lat = -1; wd = '0; be = '0; proto_ok = 1'b1;
    @(negedge g_clk);
    drive(wide, 1'b1, s, im, r1, r3);
    for (int j = 1; j <= 20 && !got; j++) begin
      @(negedge g_clk);
      if (cur_idone(wide)) begin
        got = 1'b1;
        lat = j;
        wd  = wide ? b_wdata : {32'h0, a_wdata};
        be  = wide ? b_ben : {4'h0, a_ben};
        if (!cur_busy(wide)) proto_ok = 1'b0;
        drive(wide, 1'b0, s, im, r1, r3);
      end else begin
        if (!cur_busy(wide) || a_wdata != 32'h0 || b_wdata != 64'h0 ||
            a_ben != 4'h0 || b_ben != 8'h0) proto_ok = 1'b0;
      end
    end
    if (got) begin
      @(negedge g_clk);
      if (cur_busy(wide) || cur_idone(wide)) proto_ok = 1'b0;
    end else begin
      drive(wide, 1'b0, s, im, r1, r3);
    end
  endtask

  initial begin
    int          lat;
    logic [63:0] wd;
    logic [7:0]  be;
    bit          ok;
    bit          seen;
    logic [63:0] r1a, r3a, r1b, r3b, r1c, r3c;

    g_reset = 1'b1; a_ivalid = 1'b0; b_ivalid = 1'b0;
    rs1 = '0; rs3 = '0; imm = '0; sub = '0;

    r1a = {$urandom(), $urandom()}; r3a = {$urandom(), $urandom()};
    r1b = {$urandom(), $urandom()}; r3b = {$urandom(), $urandom()};
    r1c = {$urandom(), $urandom()}; r3c = {$urandom(), $urandom()};

    vecs[0]  = mk(0, SCARV_COP_SCLASS_PERM_BIT,  32'h20,  64'h0, 64'h1, 64'h2,        8'h0F, 6);
    vecs[1]  = mk(0, SCARV_COP_SCLASS_PERM_IBIT, 32'h20,  64'h0, 64'h1, 64'h10000,    8'h0F, 6);
    vecs[2]  = mk(0, SCARV_COP_SCLASS_PERM_BIT,  32'h20,  64'h1, 64'h1, 64'h3,        8'h0F, 6);
    vecs[3]  = mk(0, SCARV_COP_SCLASS_PERM_BYTE, 32'h390, 64'h11223344, 64'h0, 64'h44332211, 8'h0F, 1);
    vecs[4]  = mk(0, 5'b11111,                   32'h390, 64'h11223344, 64'h5, 64'h0, 8'h00, 1);
    vecs[5]  = mk(0, SCARV_COP_SCLASS_PERM_BIT,  32'h0,   64'h0, 64'hDEADBEEF, 64'hDEADBEEF, 8'h0F, 6);
    vecs[6]  = mk(0, SCARV_COP_SCLASS_PERM_BIT,  32'h3E0, 64'h0, 64'h1, 64'h80000000, 8'h0F, 6);
    vecs[7]  = mk(1, SCARV_COP_SCLASS_PERM_BYTE, 32'h390, 64'h1122334455667788, 64'h0,
                  64'h4433221188776655, 8'hFF, 1);
    vecs[8]  = mk(1, SCARV_COP_SCLASS_PERM_BIT,  32'h20,  64'h0, 64'h1, 64'h2,         8'hFF, 4);
    vecs[9]  = mk(1, SCARV_COP_SCLASS_PERM_IBIT, 32'h20,  64'h0, 64'h1, 64'h1_0000_0000, 8'hFF, 4);
    vecs[10] = mk(1, SCARV_COP_SCLASS_PERM_BIT,  32'h0,   r1a, r3a, r3a, 8'hFF, 4);
    vecs[11] = mk(1, SCARV_COP_SCLASS_PERM_BIT,  32'h7E0, r1b, r3b,
                  model(6, 1'b0, 6'h3F, r1b, r3b), 8'hFF, 4);
    vecs[12] = mk(1, SCARV_COP_SCLASS_PERM_IBIT, 32'h7E0, r1c, r3c,
                  model(6, 1'b1, 6'h3F, r1c, r3c), 8'hFF, 4);

    repeat (2) @(negedge g_clk);
    check("reset_a_outputs", {59'h0, a_idone, a_busy, a_ben} | {32'h0, a_wdata}, 64'h0);
    check("reset_b_outputs", {54'h0, b_idone, b_busy, b_ben} | b_wdata, 64'h0);
    g_reset = 1'b0;

    // Table-driven operations.
    for (int i = 0; i < 13; i++) begin
      run_op(vecs[i].wide, vecs[i].sub, vecs[i].imm, vecs[i].rs1, vecs[i].rs3, lat, wd, be, ok);
      check($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
      check($sformatf("v%0d_wdata", i), wd, vecs[i].exp_wd);
      check($sformatf("v%0d_ben", i), {56'h0, be}, {56'h0, vecs[i].exp_ben});
      check($sformatf("v%0d_protocol", i), {63'h0, ok}, 64'h1);
    end

    // Abort: ivalid dropped in the second RUN cycle.
    @(negedge g_clk);
    drive(0, 1'b1, SCARV_COP_SCLASS_PERM_BIT, 32'h3E0, 64'h0, 64'h5);
    @(negedge g_clk);
    @(negedge g_clk);
    check("abort_busy_in_run", {63'h0, a_busy}, 64'h1);
    a_ivalid = 1'b0;
    @(negedge g_clk);
    check("abort_busy_dropped", {63'h0, a_busy}, 64'h0);
    seen = 1'b0;
    for (int j = 0; j < 8; j++) begin
      if (a_idone) seen = 1'b1;
      @(negedge g_clk);
    end
    check("abort_no_idone", {63'h0, seen}, 64'h0);
    run_op(0, SCARV_COP_SCLASS_PERM_BIT, 32'h20, 64'h0, 64'h1, lat, wd, be, ok);
    check("after_abort_latency", 64'(lat), 64'd6);
    check("after_abort_wdata", wd, 64'h2);

    // Reset in the middle of RUN.
    @(negedge g_clk);
    drive(0, 1'b1, SCARV_COP_SCLASS_PERM_IBIT, 32'h3E0, 64'h0, 64'h1);
    @(negedge g_clk);
    @(negedge g_clk);
    check("rst_pre_busy", {63'h0, a_busy}, 64'h1);
    g_reset = 1'b1;
    a_ivalid = 1'b0;
    #1;
    check("rst_outputs_zero", {59'h0, a_idone, a_busy, a_ben} | {32'h0, a_wdata}, 64'h0);
    @(negedge g_clk);
    g_reset = 1'b0;
    seen = 1'b0;
    for (int j = 0; j < 8; j++) begin
      @(negedge g_clk);
      if (a_idone || a_busy) seen = 1'b1;
    end
    check("rst_no_idone_after", {63'h0, seen}, 64'h0);

    // ivalid still high during DONE must not start another operation.
    @(negedge g_clk);
    drive(0, 1'b1, SCARV_COP_SCLASS_PERM_BYTE, 32'h390, 64'hA1B2C3D4, 64'h0);
    @(negedge g_clk);
    check("done_idone", {63'h0, a_idone}, 64'h1);
    check("done_wdata", {32'h0, a_wdata}, 64'hD4C3B2A1);
    @(negedge g_clk);
    check("done_no_reaccept", {62'h0, a_busy, a_idone}, 64'h0);
    a_ivalid = 1'b0;
    @(negedge g_clk);
    check("done_still_idle", {62'h0, a_busy, a_idone}, 64'h0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
